// File: rtl/i_fetch.sv
// Instruction fetch unit: drives byte addresses to the instruction memory,
// captures the word returned one cycle later into a 2-entry prefetch FIFO,
// and hands instructions to decode with a valid/ready handshake. A redirect
// from execute flushes everything in flight and restarts at the target.
module i_fetch #(
  parameter int unsigned           XLEN     = 32,
  parameter int unsigned           ADDR_LEN = 14,
  parameter logic [ADDR_LEN-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rstb,
  output logic [ADDR_LEN-1:0] i_addr,
  input  logic [XLEN-1:0]     i_rd_data,
  input  logic                redir_valid,
  input  logic [ADDR_LEN-1:0] redir_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [XLEN-1:0]     inst,
  output logic [ADDR_LEN-1:0] inst_pc
);

  // Next sequential word address; wraps modulo 2^ADDR_LEN.
  function automatic logic [ADDR_LEN-1:0] pc_inc(input logic [ADDR_LEN-1:0] pc);
    return pc + ADDR_LEN'(4);
  endfunction

  // Stage p0: address being issued this cycle.
  logic [ADDR_LEN-1:0] fetch_pc_p0;
  // Stage p1: read in flight, its data arrives on i_rd_data this cycle.
  logic                vld_p1;
  logic [ADDR_LEN-1:0] pc_p1;

  // Prefetch FIFO, entry 0 is always the head.
  logic [ADDR_LEN-1:0] fifo_pc   [2];
  logic [XLEN-1:0]     fifo_word [2];
  logic [1:0]          count;

  logic [ADDR_LEN-1:0] redir_tgt;
  logic                pop;
  logic                push;
  logic                issue;
  logic [2:0]          occupancy;
  logic                wr_hi;
  logic                unused_redir_lsb;

  // Low address bits of a redirect are forced to a word boundary.
  assign redir_tgt        = {redir_pc[ADDR_LEN-1:2], 2'b00};
  assign unused_redir_lsb = ^redir_pc[1:0];

  assign i_addr     = redir_valid ? redir_tgt : fetch_pc_p0;
  assign inst_valid = (count != 2'd0) && !redir_valid;
  assign inst       = fifo_word[0];
  assign inst_pc    = fifo_pc[0];

  assign pop  = inst_valid && inst_ready;
  assign push = vld_p1 && !redir_valid;

  // Issue only while buffered + in-flight words after this cycle's pop
  // leave room, so a returning word can never find the FIFO full.
  assign occupancy = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue     = occupancy < 3'd2;

  // Slot receiving a pushed word: after a simultaneous pop the tail moves down.
  assign wr_hi = pop ? (count == 2'd2) : (count == 2'd1);

  // PC, in-flight read and occupancy control; redirect has top priority.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      fetch_pc_p0 <= RESET_PC;
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      count       <= 2'd0;
    end else if (redir_valid) begin
      fetch_pc_p0 <= pc_inc(redir_tgt);
      vld_p1      <= 1'b1;
      pc_p1       <= redir_tgt;
      count       <= 2'd0;
    end else begin
      if (issue) begin
        fetch_pc_p0 <= pc_inc(fetch_pc_p0);
        vld_p1      <= 1'b1;
        pc_p1       <= fetch_pc_p0;
      end else begin
        vld_p1      <= 1'b0;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO storage: shift on pop, write returning word into the tail slot.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      fifo_pc[0]   <= '0;
      fifo_pc[1]   <= '0;
      fifo_word[0] <= '0;
      fifo_word[1] <= '0;
    end else if (!redir_valid) begin
      if (pop) begin
        fifo_pc[0]   <= fifo_pc[1];
        fifo_word[0] <= fifo_word[1];
      end
      if (push) begin
        if (wr_hi) begin
          fifo_pc[1]   <= pc_p1;
          fifo_word[1] <= i_rd_data;
        end else begin
          fifo_pc[0]   <= pc_p1;
          fifo_word[0] <= i_rd_data;
        end
      end
    end
  end

endmodule
